// File: rtl/clock_pkg.sv
// Shared definitions for the clock time counter and the alarm-set stage.
package clock_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned SEL_W = 2;

    // time_set_select encodings
    typedef enum logic [SEL_W-1:0] {
        SEL_RUN  = 2'b00,
        SEL_HOUR = 2'b01,
        SEL_MIN  = 2'b10,
        SEL_SEC  = 2'b11
    } time_sel_e;

    // BCD field limits
    localparam logic [BCD_W-1:0] BCD_MAX_MS   = 8'h59;
    localparam logic [BCD_W-1:0] BCD_MAX_HOUR = 8'h23;

    // Chime seconds (all within minute 59)
    localparam logic [BCD_W-1:0] CHIME_S51 = 8'h51;
    localparam logic [BCD_W-1:0] CHIME_S53 = 8'h53;
    localparam logic [BCD_W-1:0] CHIME_S55 = 8'h55;
    localparam logic [BCD_W-1:0] CHIME_S57 = 8'h57;
    localparam logic [BCD_W-1:0] CHIME_S59 = 8'h59;

    // True when both digits are decimal and the value does not exceed max_bcd
    function automatic logic bcd_is_legal(input logic [BCD_W-1:0] v,
                                          input logic [BCD_W-1:0] max_bcd);
        return (v[3:0] <= 4'd9) && (v <= max_bcd);
    endfunction

    // One BCD step with wrap at max_bcd; an illegal value collapses to 00
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] max_bcd);
        logic [BCD_W-1:0] r;
        if (!bcd_is_legal(v, max_bcd) || (v == max_bcd)) begin
            r = '0;
        end else if (v[3:0] == 4'd9) begin
            r = {4'(v[7:4] + 4'd1), 4'd0};
        end else begin
            r = {v[7:4], 4'(v[3:0] + 4'd1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous clear and wrap carry.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = 8'h59,
    parameter logic [7:0] INIT    = 8'h00
) (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       load_zero,
    input  logic       inc,
    output logic [7:0] value,
    output logic       carry
);

    logic [BCD_W-1:0] r_value;
    logic [BCD_W-1:0] w_next;

    // Next value: clear wins over increment, otherwise hold
    always_comb begin
        w_next = r_value;
        if (load_zero) begin
            w_next = '0;
        end else if (inc) begin
            w_next = bcd_inc(r_value, MAX_BCD);
        end
    end

    // Field register, asynchronously cleared to INIT
    always_ff @(posedge clk_1hz or negedge cr) begin
        if (!cr) begin
            r_value <= INIT;
        end else begin
            r_value <= w_next;
        end
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX_BCD);

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour BCD timekeeping core with hour/minute set, seconds clear and hourly chime.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] INIT_HOUR   = 8'h00,
    parameter logic [7:0] INIT_MINUTE = 8'h00,
    parameter logic [7:0] INIT_SECOND = 8'h00,
    parameter bit         CHIME_EN    = 1'b1
) (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       en,
    input  logic [1:0] time_set_select,
    input  logic       set_confirm,
    output logic [7:0] clock_hour,
    output logic [7:0] clock_minute,
    output logic [7:0] clock_second,
    output logic       chime_lo,
    output logic       chime_hi
);

    time_sel_e w_sel;
    logic      w_sec_inc;
    logic      w_sec_clr;
    logic      w_min_inc;
    logic      w_hour_inc;
    logic      w_sec_carry;
    logic      w_min_carry;
    logic      w_day_carry_unused;
    logic      r_run;

    assign w_sel = time_sel_e'(time_set_select);

    // Mode steering: en gates everything; carries only ripple in run mode
    always_comb begin
        w_sec_inc  = 1'b0;
        w_sec_clr  = 1'b0;
        w_min_inc  = 1'b0;
        w_hour_inc = 1'b0;
        if (en) begin
            unique case (w_sel)
                SEL_RUN: begin
                    w_sec_inc  = 1'b1;
                    w_min_inc  = w_sec_carry;
                    w_hour_inc = w_min_carry;
                end
                SEL_HOUR: w_hour_inc = set_confirm;
                SEL_MIN:  w_min_inc  = set_confirm;
                SEL_SEC:  w_sec_clr  = 1'b1;
                default: ;
            endcase
        end
    end

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_MS),
        .INIT    (INIT_SECOND)
    ) u_second (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .load_zero (w_sec_clr),
        .inc       (w_sec_inc),
        .value     (clock_second),
        .carry     (w_sec_carry)
    );

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_MS),
        .INIT    (INIT_MINUTE)
    ) u_minute (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .load_zero (1'b0),
        .inc       (w_min_inc),
        .value     (clock_minute),
        .carry     (w_min_carry)
    );

    bcd_mod_counter #(
        .MAX_BCD (BCD_MAX_HOUR),
        .INIT    (INIT_HOUR)
    ) u_hour (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .load_zero (1'b0),
        .inc       (w_hour_inc),
        .value     (clock_hour),
        .carry     (w_day_carry_unused)
    );

    // Registered copy of the mode applied at the last edge, so the chime
    // depends only on state; cleared on reset so chimes start silent
    always_ff @(posedge clk_1hz or negedge cr) begin
        if (!cr) begin
            r_run <= 1'b0;
        end else if (en) begin
            r_run <= (w_sel == SEL_RUN);
        end
    end

    // Chime decode of registered time and mode
    always_comb begin
        chime_lo = 1'b0;
        chime_hi = 1'b0;
        if (CHIME_EN && r_run && (clock_minute == BCD_MAX_MS)) begin
            chime_lo = (clock_second == CHIME_S51) || (clock_second == CHIME_S53) ||
                       (clock_second == CHIME_S55) || (clock_second == CHIME_S57);
            chime_hi = (clock_second == CHIME_S59);
        end
    end

endmodule
